// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of apb_master_arbiter.
// Suffixes are given from the arbiter's point of view.
interface apb_master_arbiter_if #(
    parameter int unsigned NB_REQ         = 2,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [NB_REQ-1:0]                req_valid_i;
    logic [NB_REQ-1:0]                req_ready_o;
    logic [NB_REQ*APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [NB_REQ-1:0]                req_write_i;
    logic [NB_REQ*APB_DATA_WIDTH-1:0] req_wdata_i;
    logic [NB_REQ-1:0]                rsp_valid_o;
    logic [APB_DATA_WIDTH-1:0]        rsp_rdata_o;
    logic                             rsp_err_o;
    logic [APB_ADDR_WIDTH-1:0]        paddr_o;
    logic [APB_DATA_WIDTH-1:0]        pwdata_o;
    logic                             pwrite_o;
    logic                             psel_o;
    logic                             penable_o;
    logic [APB_DATA_WIDTH-1:0]        prdata_i;
    logic                             pready_i;
    logic                             pslverr_i;

    // Arbiter side: requesters and the APB slave are its inputs.
    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    // Environment side: requesters plus the APB peripheral.
    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NB_REQ requesters,
// with a watchdog that aborts ACCESS phases the peripheral never completes.
module apb_master_arbiter #(
    parameter int unsigned NB_REQ         = 2,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                  clk_i,
    input logic                  rst_i,
    apb_master_arbiter_if.master bus
);
    localparam int unsigned IdxW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CntW-1:0] CntLast =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]           cur_q, cur_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic [NB_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

    logic [NB_REQ-1:0]         req_ready;
    logic                      gnt_found;
    logic [IdxW-1:0]           gnt_idx;
    int unsigned               cand;
    logic                      timeout;

    logic [APB_ADDR_WIDTH-1:0] addr_arr  [NB_REQ];
    logic [APB_DATA_WIDTH-1:0] wdata_arr [NB_REQ];

    for (genvar i = 0; i < NB_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = bus.req_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        assign wdata_arr[i] = bus.req_wdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    // First valid requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned off = 0; off < NB_REQ; off++) begin
            cand = (32'(rr_ptr_q) + off) % NB_REQ;
            if (!gnt_found && bus.req_valid_i[IdxW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'(cand);
            end
        end
    end

    assign timeout = TimeoutEn && (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;

        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    cur_d     = gnt_idx;
                    paddr_d   = addr_arr[gnt_idx];
                    pwdata_d  = wdata_arr[gnt_idx];
                    pwrite_d  = bus.req_write_i[gnt_idx];
                    rr_ptr_d  = (gnt_idx == IdxW'(NB_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d     = '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                // pready takes priority over a timeout landing in the same cycle.
                if (bus.pready_i) begin
                    rsp_valid_d[cur_q] = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    rsp_err_d   = bus.pslverr_i;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = StIdle;
                end else if (timeout) begin
                    rsp_valid_d[cur_q] = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready_o = rst_i ? '0 : req_ready;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
endmodule
